// File: rtl/arbitro_vc_ctrl_pkg.sv
// rtl/arbitro_vc_ctrl_pkg.sv - shared constants, state encoding and routing helper
package arbitro_vc_ctrl_pkg;
  localparam int DATA_WIDTH = 6;
  localparam int ADDR_WIDTH = 2;
  localparam logic [ADDR_WIDTH:0] D_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam int DEST_BIT = 4;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_INIT,
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR
  } state_e;

  // Destination FIFO index carried in the head word: 0 -> D0, 1 -> D1.
  function automatic logic dest_of(input logic [DATA_WIDTH-1:0] word);
    return word[DEST_BIT];
  endfunction
endpackage

// File: rtl/arbitro_vc_ctrl_if.sv
// rtl/arbitro_vc_ctrl_if.sv - VC FIFO heads/pops and D FIFO counts/pushes seen by the controller
interface arbitro_vc_ctrl_if;
  import arbitro_vc_ctrl_pkg::*;

  logic [DATA_WIDTH-1:0] vc0_data;
  logic [DATA_WIDTH-1:0] vc1_data;
  logic                  vc0_empty;
  logic                  vc1_empty;
  logic                  vc0_pop;
  logic                  vc1_pop;
  logic [ADDR_WIDTH:0]   d0_count;
  logic [ADDR_WIDTH:0]   d1_count;
  logic                  d0_push;
  logic                  d1_push;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    input  vc0_data, vc1_data, vc0_empty, vc1_empty, d0_count, d1_count,
    output vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );

  modport slave (
    output vc0_data, vc1_data, vc0_empty, vc1_empty, d0_count, d1_count,
    input  vc0_pop, vc1_pop, d0_push, d1_push, data_out
  );
endinterface

// File: rtl/arbitro_prioridad.sv
// rtl/arbitro_prioridad.sv - fixed VC0 priority with starvation override toward VC1
module arbitro_prioridad (
  input  logic [1:0] req,
  input  logic [3:0] starve_cnt,
  input  logic [3:0] umbral_vcs,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[0] && !(req[1] && (starve_cnt >= umbral_vcs))) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end
endmodule

// File: rtl/arbitro_vc_ctrl.sv
// rtl/arbitro_vc_ctrl.sv - link FSM, threshold latches and VC-to-D transfer sequencing
module arbitro_vc_ctrl
  import arbitro_vc_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [3:0]        umbral_VCs_in,
  input  logic [3:0]        umbral_Ds_in,
  input  logic              fifo_error,
  arbitro_vc_ctrl_if.master bus,
  output logic [3:0]        umbral_VCs,
  output logic [3:0]        umbral_Ds,
  output logic              idle_out,
  output logic              active_out,
  output logic              error_out
);
  state_e                state_q, state_d;
  logic [3:0]            umbral_vcs_q, umbral_vcs_d;
  logic [3:0]            umbral_ds_q, umbral_ds_d;
  logic [3:0]            starve_cnt_q, starve_cnt_d;
  logic                  d0_push_q, d0_push_d;
  logic                  d1_push_q, d1_push_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  idle_q, idle_d;
  logic                  active_q, active_d;
  logic                  error_q, error_d;

  logic                  error_det;
  logic                  grant_en;
  logic [1:0]            d_blocked;
  logic                  elig0, elig1;
  logic [1:0]            gnt;
  logic [DATA_WIDTH-1:0] head;

  assign error_det = fifo_error || (bus.d0_count > D_DEPTH) || (bus.d1_count > D_DEPTH);
  assign grant_en  = !reset && init && !error_det &&
                     ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));

  // The in-flight push counts as occupancy so a threshold equal to depth never overfills.
  assign d_blocked[0] = (4'(bus.d0_count) + 4'(d0_push_q)) >= umbral_ds_q;
  assign d_blocked[1] = (4'(bus.d1_count) + 4'(d1_push_q)) >= umbral_ds_q;
  assign elig0 = !bus.vc0_empty && !d_blocked[dest_of(bus.vc0_data)];
  assign elig1 = !bus.vc1_empty && !d_blocked[dest_of(bus.vc1_data)];

  arbitro_prioridad u_prioridad (
    .req        ({elig1, elig0} & {2{grant_en}}),
    .starve_cnt (starve_cnt_q),
    .umbral_vcs (umbral_vcs_q),
    .gnt        (gnt)
  );

  assign head = gnt[1] ? bus.vc1_data : bus.vc0_data;

  always_comb begin
    state_d      = state_q;
    umbral_vcs_d = umbral_vcs_q;
    umbral_ds_d  = umbral_ds_q;
    starve_cnt_d = starve_cnt_q;
    data_d       = data_q;
    d0_push_d    = 1'b0;
    d1_push_d    = 1'b0;

    if (|gnt) begin
      data_d = head;
      if (dest_of(head)) d1_push_d = 1'b1;
      else               d0_push_d = 1'b1;
    end

    if (gnt[0] && elig1) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end else if (gnt[1] || !elig1) begin
      starve_cnt_d = 4'd0;
    end

    if (state_q == ST_INIT) begin
      umbral_vcs_d = umbral_VCs_in;
      umbral_ds_d  = umbral_Ds_in;
    end

    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = init ? ST_IDLE : ST_INIT;
      ST_IDLE,
      ST_ACTIVE: begin
        if (!init) begin
          state_d = ST_INIT;
        end else if (!bus.vc0_empty || !bus.vc1_empty || d0_push_q || d1_push_q) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if ((state_q != ST_RESET) && error_det) state_d = ST_ERROR;

    idle_d   = (state_d == ST_IDLE);
    active_d = (state_d == ST_ACTIVE);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      umbral_vcs_q <= 4'd0;
      umbral_ds_q  <= 4'd0;
      starve_cnt_q <= 4'd0;
      d0_push_q    <= 1'b0;
      d1_push_q    <= 1'b0;
      data_q       <= '0;
      idle_q       <= 1'b0;
      active_q     <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      umbral_vcs_q <= umbral_vcs_d;
      umbral_ds_q  <= umbral_ds_d;
      starve_cnt_q <= starve_cnt_d;
      d0_push_q    <= d0_push_d;
      d1_push_q    <= d1_push_d;
      data_q       <= data_d;
      idle_q       <= idle_d;
      active_q     <= active_d;
      error_q      <= error_d;
    end
  end

  assign bus.vc0_pop  = gnt[0];
  assign bus.vc1_pop  = gnt[1];
  assign bus.d0_push  = d0_push_q;
  assign bus.d1_push  = d1_push_q;
  assign bus.data_out = data_q;
  assign umbral_VCs   = umbral_vcs_q;
  assign umbral_Ds    = umbral_ds_q;
  assign idle_out     = idle_q;
  assign active_out   = active_q;
  assign error_out    = error_q;
endmodule

// File: tb/tb_arbitro_vc_ctrl.sv
// tb/tb_arbitro_vc_ctrl.sv - directed vector table plus hand sequences for arbitro_vc_ctrl
module tb_arbitro_vc_ctrl;
  logic       clk;
  logic       reset;
  logic       init;
  logic [3:0] uvc_in, uds_in;
  logic       ferr;
  logic [3:0] uvc, uds;
  logic       idle_out, active_out, error_out;

  arbitro_vc_ctrl_if bus ();

  arbitro_vc_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .init          (init),
    .umbral_VCs_in (uvc_in),
    .umbral_Ds_in  (uds_in),
    .fifo_error    (ferr),
    .bus           (bus),
    .umbral_VCs    (uvc),
    .umbral_Ds     (uds),
    .idle_out      (idle_out),
    .active_out    (active_out),
    .error_out     (error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pop/push are {vc1,vc0} and {d1,d0}; flags are {idle,active,error}.
  typedef struct {
    logic       rst, ini, fe;
    logic       v0e;
    logic [5:0] v0d;
    logic       v1e;
    logic [5:0] v1d;
    logic [2:0] d0c, d1c;
    logic [3:0] uvci, udsi;
    logic [1:0] pop, push;
    logic [5:0] data;
    logic [2:0] flags;
    logic [3:0] uvc, uds;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic add(input logic rst, ini, fe, v0e, input logic [5:0] v0d,
                     input logic v1e, input logic [5:0] v1d, input logic [2:0] d0c, d1c,
                     input logic [3:0] uvci, udsi, input logic [1:0] pop, push,
                     input logic [5:0] data, input logic [2:0] flags, input logic [3:0] euvc, euds);
    vec_t t;
    t.rst = rst; t.ini = ini; t.fe = fe; t.v0e = v0e; t.v0d = v0d; t.v1e = v1e; t.v1d = v1d;
    t.d0c = d0c; t.d1c = d1c; t.uvci = uvci; t.udsi = udsi; t.pop = pop; t.push = push;
    t.data = data; t.flags = flags; t.uvc = euvc; t.uds = euds;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [1:0] pop_act;
    logic       ok;
    vec_t       t;

    reset = 1'b1; init = 1'b0; ferr = 1'b0; uvc_in = 4'd1; uds_in = 4'd2;
    bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1; bus.vc0_data = '0; bus.vc1_data = '0;
    bus.d0_count = '0; bus.d1_count = '0;
    @(posedge clk); @(posedge clk); #1;

    //  rst i fe v0e v0d  v1e v1d  d0c d1c uvci udsi pop   push  data  flags  uvc uds
    add(1, 0, 0, 1, 6'h00, 1, 6'h00, 0, 0, 1, 2, 2'b00, 2'b00, 6'h00, 3'b000, 0, 0);
    add(0, 1, 0, 1, 6'h00, 1, 6'h00, 0, 0, 1, 2, 2'b00, 2'b00, 6'h00, 3'b000, 0, 0);
    add(0, 1, 0, 1, 6'h00, 1, 6'h00, 0, 0, 1, 2, 2'b00, 2'b00, 6'h00, 3'b100, 1, 2);
    add(0, 1, 0, 0, 6'h08, 1, 6'h00, 0, 0, 1, 2, 2'b01, 2'b01, 6'h08, 3'b010, 1, 2);
    add(0, 1, 0, 0, 6'h15, 1, 6'h00, 0, 0, 1, 2, 2'b01, 2'b10, 6'h15, 3'b010, 1, 2);
    add(0, 1, 0, 1, 6'h00, 1, 6'h00, 0, 0, 1, 2, 2'b00, 2'b00, 6'h00, 3'b010, 1, 2);
    add(0, 1, 0, 1, 6'h00, 1, 6'h00, 0, 0, 1, 2, 2'b00, 2'b00, 6'h00, 3'b100, 1, 2);
    add(0, 1, 0, 0, 6'h01, 0, 6'h02, 0, 0, 1, 2, 2'b01, 2'b01, 6'h01, 3'b010, 1, 2);
    add(0, 1, 0, 0, 6'h03, 0, 6'h02, 0, 0, 1, 2, 2'b10, 2'b01, 6'h02, 3'b010, 1, 2);
    add(0, 1, 0, 0, 6'h03, 0, 6'h04, 0, 0, 1, 2, 2'b01, 2'b01, 6'h03, 3'b010, 1, 2);
    add(0, 1, 0, 0, 6'h05, 0, 6'h04, 0, 0, 1, 2, 2'b10, 2'b01, 6'h04, 3'b010, 1, 2);
    add(0, 0, 0, 1, 6'h00, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b000, 1, 2);
    add(0, 1, 0, 1, 6'h00, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b100, 3, 2);
    add(0, 1, 0, 0, 6'h06, 0, 6'h0A, 0, 0, 3, 2, 2'b01, 2'b01, 6'h06, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h07, 0, 6'h0A, 0, 0, 3, 2, 2'b01, 2'b01, 6'h07, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h09, 0, 6'h0A, 0, 0, 3, 2, 2'b01, 2'b01, 6'h09, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h0B, 0, 6'h0A, 0, 0, 3, 2, 2'b10, 2'b01, 6'h0A, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h0B, 0, 6'h12, 1, 0, 3, 2, 2'b10, 2'b10, 6'h12, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h0B, 1, 6'h00, 1, 0, 3, 2, 2'b01, 2'b01, 6'h0B, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h0C, 1, 6'h00, 2, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b010, 3, 2);
    add(0, 1, 0, 0, 6'h0C, 1, 6'h00, 0, 0, 3, 2, 2'b01, 2'b01, 6'h0C, 3'b010, 3, 2);
    add(0, 0, 0, 0, 6'h0D, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b000, 3, 2);
    add(0, 1, 0, 0, 6'h0D, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b100, 3, 2);
    add(0, 1, 0, 0, 6'h0D, 1, 6'h00, 0, 0, 3, 2, 2'b01, 2'b01, 6'h0D, 3'b010, 3, 2);
    add(0, 1, 1, 0, 6'h0E, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b001, 3, 2);
    add(0, 1, 0, 0, 6'h0E, 1, 6'h00, 0, 0, 3, 2, 2'b00, 2'b00, 6'h00, 3'b001, 3, 2);

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      reset = t.rst; init = t.ini; ferr = t.fe; uvc_in = t.uvci; uds_in = t.udsi;
      bus.vc0_empty = t.v0e; bus.vc0_data = t.v0d; bus.vc1_empty = t.v1e; bus.vc1_data = t.v1d;
      bus.d0_count = t.d0c; bus.d1_count = t.d1c;
      @(negedge clk);
      pop_act = {bus.vc1_pop, bus.vc0_pop};
      @(posedge clk); #1;
      ok = (pop_act === t.pop) && ({bus.d1_push, bus.d0_push} === t.push) &&
           ({idle_out, active_out, error_out} === t.flags) && (uvc === t.uvc) && (uds === t.uds) &&
           ((t.push == 2'b00) || (bus.data_out === t.data));
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL vec%0d: pop=%b push=%b data=%h flags=%b uvc=%0d uds=%0d expected pop=%b push=%b data=%h flags=%b uvc=%0d uds=%0d",
                 i, pop_act, {bus.d1_push, bus.d0_push}, bus.data_out,
                 {idle_out, active_out, error_out}, uvc, uds,
                 t.pop, t.push, t.data, t.flags, t.uvc, t.uds);
      end
    end

    // ERROR stays sticky whatever init or the VC heads do.
    for (int i = 0; i < 4; i++) begin
      init = (i != 2); bus.vc1_empty = 1'b0; bus.vc1_data = 6'h03;
      @(negedge clk);
      chk("err_pop", 32'({bus.vc1_pop, bus.vc0_pop}), 32'd0);
      @(posedge clk); #1;
      chk("err_sticky", 32'({idle_out, active_out, error_out}), 32'b001);
    end

    reset = 1'b1; init = 1'b1; bus.vc0_empty = 1'b1; bus.vc1_empty = 1'b1;
    @(posedge clk); #1;
    chk("rst_clear", 32'({bus.d1_push, bus.d0_push, idle_out, active_out, error_out, uvc, uds}), 32'd0);

    reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_again", 32'({idle_out, active_out, error_out}), 32'b100);

    bus.vc0_empty = 1'b0; bus.vc0_data = 6'h11;
    @(posedge clk); #1;
    chk("push_before_rst", 32'({bus.d1_push, bus.d0_push, bus.data_out}), 32'({2'b10, 6'h11}));

    reset = 1'b1;
    @(negedge clk);
    chk("rst_pop", 32'({bus.vc1_pop, bus.vc0_pop}), 32'd0);
    @(posedge clk); #1;
    chk("rst_push", 32'({bus.d1_push, bus.d0_push, idle_out, active_out, error_out}), 32'd0);

    reset = 1'b0; bus.vc0_empty = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.d1_count = 3'd5;
    @(posedge clk); #1;
    chk("count_err", 32'({idle_out, active_out, error_out}), 32'b001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
